// File: rtl/rs_syndrome.sv
// Byte-serial RS(255,239) syndrome calculator over GF(2^8) (poly 0x11D, alpha = 0x02).
// Horner-evaluates each 255-symbol codeword at alpha^1..alpha^16 and double-buffers the result.
module rs_syndrome (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       din_sop,
    output logic [7:0] syndrome0,
    output logic [7:0] syndrome1,
    output logic [7:0] syndrome2,
    output logic [7:0] syndrome3,
    output logic [7:0] syndrome4,
    output logic [7:0] syndrome5,
    output logic [7:0] syndrome6,
    output logic [7:0] syndrome7,
    output logic [7:0] syndrome8,
    output logic [7:0] syndrome9,
    output logic [7:0] syndrome10,
    output logic [7:0] syndrome11,
    output logic [7:0] syndrome12,
    output logic [7:0] syndrome13,
    output logic [7:0] syndrome14,
    output logic [7:0] syndrome15,
    output logic       syn_valid,
    output logic       err_flag,
    output logic       busy
);

    localparam logic [7:0] LAST_CNT = 8'd254;

    logic [7:0] acc    [16];
    logic [7:0] syn    [16];
    logic [7:0] horner [16];
    logic [7:0] cnt;
    logic       horner_any;
    logic       take_sop;
    logic       take_data;
    logic       take_last;

    // Multiply by alpha^k with k constant at every call site, so this folds to an XOR network.
    function automatic logic [7:0] mul_alpha_pow(input logic [7:0] a, input int k);
        logic [7:0] x;
        x = a;
        for (int j = 0; j < 16; j++) begin
            if (j < k) begin
                x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
            end
        end
        return x;
    endfunction

    always_comb begin
        horner_any = 1'b0;
        for (int i = 0; i < 16; i++) begin
            horner[i]  = mul_alpha_pow(acc[i], i + 1) ^ din;
            horner_any = horner_any | (|horner[i]);
        end
    end

    always_comb begin
        take_sop  = din_valid & din_sop;
        take_data = din_valid & ~din_sop & busy;
        take_last = take_data & (cnt == LAST_CNT);
    end

    // A sop always restarts the frame; non-sop symbols outside a frame are dropped.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < 16; i++) begin
                acc[i] <= 8'h00;
                syn[i] <= 8'h00;
            end
            cnt       <= 8'd0;
            busy      <= 1'b0;
            syn_valid <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            syn_valid <= 1'b0;
            if (take_sop) begin
                for (int i = 0; i < 16; i++) begin
                    acc[i] <= din;
                end
                cnt  <= 8'd1;
                busy <= 1'b1;
            end else if (take_last) begin
                for (int i = 0; i < 16; i++) begin
                    syn[i] <= horner[i];
                    acc[i] <= 8'h00;
                end
                err_flag  <= horner_any;
                cnt       <= 8'd0;
                busy      <= 1'b0;
                syn_valid <= 1'b1;
            end else if (take_data) begin
                for (int i = 0; i < 16; i++) begin
                    acc[i] <= horner[i];
                end
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign syndrome0  = syn[0];
    assign syndrome1  = syn[1];
    assign syndrome2  = syn[2];
    assign syndrome3  = syn[3];
    assign syndrome4  = syn[4];
    assign syndrome5  = syn[5];
    assign syndrome6  = syn[6];
    assign syndrome7  = syn[7];
    assign syndrome8  = syn[8];
    assign syndrome9  = syn[9];
    assign syndrome10 = syn[10];
    assign syndrome11 = syn[11];
    assign syndrome12 = syn[12];
    assign syndrome13 = syn[13];
    assign syndrome14 = syn[14];
    assign syndrome15 = syn[15];

endmodule

// File: tb/tb_rs_syndrome.sv
// Directed self-checking bench for rs_syndrome using hand-computed GF(2^8) syndrome tables.
module tb_rs_syndrome;

    logic       clk = 1'b0;
    logic       clrn;
    logic [7:0] din;
    logic       din_valid;
    logic       din_sop;
    logic [7:0] syn_obs [16];
    logic       syn_valid;
    logic       err_flag;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;
    int pulse_count = 0;
    int last_pulse = 0;
    int prev_pulse = 0;
    int base;

    // alpha^-(i+1): single 0x01 at degree 254
    logic [7:0] alpha_neg [16] = '{8'h8E, 8'h47, 8'hAD, 8'hD8, 8'h6C, 8'h36, 8'h1B, 8'h83,
                                   8'hCF, 8'hE9, 8'hFA, 8'h7D, 8'hB0, 8'h58, 8'h2C, 8'h16};
    // alpha^(i+1): single 0x01 at degree 1
    logic [7:0] alpha_pos [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D,
                                   8'h3A, 8'h74, 8'hE8, 8'hCD, 8'h87, 8'h13, 8'h26, 8'h4C};

    rs_syndrome dut (
        .clk(clk), .clrn(clrn), .din(din), .din_valid(din_valid), .din_sop(din_sop),
        .syndrome0(syn_obs[0]),   .syndrome1(syn_obs[1]),   .syndrome2(syn_obs[2]),
        .syndrome3(syn_obs[3]),   .syndrome4(syn_obs[4]),   .syndrome5(syn_obs[5]),
        .syndrome6(syn_obs[6]),   .syndrome7(syn_obs[7]),   .syndrome8(syn_obs[8]),
        .syndrome9(syn_obs[9]),   .syndrome10(syn_obs[10]), .syndrome11(syn_obs[11]),
        .syndrome12(syn_obs[12]), .syndrome13(syn_obs[13]), .syndrome14(syn_obs[14]),
        .syndrome15(syn_obs[15]),
        .syn_valid(syn_valid), .err_flag(err_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (syn_valid) begin
            pulse_count <= pulse_count + 1;
            prev_pulse  <= last_pulse;
            last_pulse  <= cycle;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // kind 0: all zero, 1: 0x01 at degree 0, 2: 0x01 at degree 254, 3: 0x01 at degree 1
    function automatic logic [7:0] frameSym(input int kind, input int idx);
        case (kind)
            1:       return (idx == 254) ? 8'h01 : 8'h00;
            2:       return (idx == 0)   ? 8'h01 : 8'h00;
            3:       return (idx == 253) ? 8'h01 : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic sendSymbol(input logic [7:0] d, input logic s);
        din       = d;
        din_valid = 1'b1;
        din_sop   = s;
        @(negedge clk);
        din_valid = 1'b0;
        din_sop   = 1'b0;
    endtask

    task automatic applyStimulus(input int kind, input int gap_pct);
        for (int idx = 0; idx < 255; idx++) begin
            for (int g = 0; g < 4 && $urandom_range(0, 99) < gap_pct; g++) begin
                din       = 8'($urandom_range(0, 255));
                din_valid = 1'b0;
                din_sop   = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            sendSymbol(frameSym(kind, idx), idx == 0);
        end
    endtask

    task automatic checkSyndromes(input string tag, input int kind, input logic exp_err);
        logic [7:0] exp;
        checkOutput({tag, " syn_valid"}, syn_valid, 1);
        checkOutput({tag, " err_flag"}, err_flag, exp_err);
        checkOutput({tag, " busy"}, busy, 0);
        for (int i = 0; i < 16; i++) begin
            case (kind)
                1:       exp = 8'h01;
                2:       exp = alpha_neg[i];
                3:       exp = alpha_pos[i];
                default: exp = 8'h00;
            endcase
            checkOutput($sformatf("%s syn%0d", tag, i), syn_obs[i], exp);
        end
    endtask

    task automatic checkAfterPulse(input string tag, input int exp_pulses);
        @(negedge clk);
        checkOutput({tag, " syn_valid drop"}, syn_valid, 0);
        checkOutput({tag, " pulse count"}, pulse_count - base, exp_pulses);
    endtask

    initial begin
        clrn = 1'b0;
        din = 8'h00;
        din_valid = 1'b0;
        din_sop = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset syn_valid", syn_valid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset err_flag", err_flag, 0);
        for (int i = 0; i < 16; i++) checkOutput($sformatf("reset syn%0d", i), syn_obs[i], 0);
        clrn = 1'b1;
        @(negedge clk);

        $display("[TB] all-zero frame");
        base = pulse_count;
        applyStimulus(0, 0);
        checkSyndromes("zero", 0, 1'b0);
        checkAfterPulse("zero", 1);

        $display("[TB] stray symbols then degree-0 error");
        for (int k = 0; k < 3; k++) sendSymbol(8'hFF, 1'b0);
        checkOutput("stray busy", busy, 0);
        base = pulse_count;
        applyStimulus(1, 0);
        checkSyndromes("deg0", 1, 1'b1);
        checkAfterPulse("deg0", 1);

        $display("[TB] degree-254 error");
        base = pulse_count;
        applyStimulus(2, 0);
        checkSyndromes("deg254", 2, 1'b1);
        checkAfterPulse("deg254", 1);

        $display("[TB] degree-254 error with gaps");
        base = pulse_count;
        applyStimulus(2, 30);
        checkSyndromes("gaps", 2, 1'b1);
        checkAfterPulse("gaps", 1);

        $display("[TB] aborted frame then zero frame");
        base = pulse_count;
        for (int k = 0; k < 100; k++) sendSymbol(8'h5A, k == 0);
        checkOutput("abort busy", busy, 1);
        checkOutput("abort hold syn0", syn_obs[0], 8'h8E);
        applyStimulus(0, 0);
        checkSyndromes("abort", 0, 1'b0);
        checkAfterPulse("abort", 1);

        $display("[TB] reset mid-frame");
        base = pulse_count;
        for (int k = 0; k < 200; k++) sendSymbol(8'h33, k == 0);
        clrn = 1'b0;
        #2;
        checkOutput("midreset busy", busy, 0);
        checkOutput("midreset syn_valid", syn_valid, 0);
        @(negedge clk);
        clrn = 1'b1;
        applyStimulus(1, 0);
        checkSyndromes("postreset", 1, 1'b1);
        checkAfterPulse("postreset", 1);

        $display("[TB] back-to-back frames");
        base = pulse_count;
        applyStimulus(3, 0);
        checkSyndromes("b2b first", 3, 1'b1);
        applyStimulus(1, 0);
        checkSyndromes("b2b second", 1, 1'b1);
        checkAfterPulse("b2b", 2);
        checkOutput("b2b spacing", last_pulse - prev_pulse, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rs_syndrome.md
# rs_syndrome

Byte-serial syndrome calculator for the RS(255,239) decoder over GF(2^8), field polynomial x^8+x^4+x^3+x^2+1 (0x11D), α = 0x02. Accepts one received symbol per valid cycle, highest-degree coefficient first. Evaluates the received polynomial at α^1..α^16 and presents the 16 syndromes, held stable, to the Berlekamp stage. The syndrome set is double-buffered, so the next codeword streams in while the current syndromes are consumed.

## Interface
- No parameters. n = 255, 2t = 16, field and α fixed.
- clk  in  1  rising-edge clock
- clrn  in  1  reset, asynchronous, active-low
- din  in  8  received symbol
- din_valid  in  1  din accepted on this edge when high
- din_sop  in  1  first symbol of a codeword; qualified by din_valid
- syndrome0..syndrome15  out  8 each  registered syndromes; syndrome_i = R(α^(i+1))
- syn_valid  out  1  one-cycle pulse; new syndrome set loaded
- err_flag  out  1  registered; high when any syndrome in the current output set is nonzero
- busy  out  1  registered; high while a codeword is partially received

## Operation
- Accumulators acc0..acc15 (8 b) and symbol counter cnt (8 b, 0..254). Horner update on each accepted symbol: acc_i <= (acc_i · α^(i+1)) ⊕ din. The α^(i+1) multiplies are constant GF multipliers (XOR networks).
- On an accepted symbol with din_sop: the update uses acc_i = 0, giving acc_i <= din; cnt <= 1; busy <= 1. This restarts the codeword even mid-frame; the partial frame is discarded and produces no syn_valid.
- On an accepted symbol without din_sop while busy: Horner update; cnt <= cnt+1.
- On an accepted symbol with busy=0 and no din_sop: symbol ignored, no state change.
- Last symbol, when the accepted symbol makes cnt reach 255: on that edge syndrome_i <= (acc_i·α^(i+1)) ⊕ din; err_flag <= OR of those 16 values; accumulators cleared; cnt <= 0; busy <= 0; syn_valid <= 1 for the next cycle only.
- A 1-symbol frame that is both sop and last cannot occur, because n = 255.
- If din_sop arrives on the edge right after the last symbol, the new frame starts normally. Outputs hold the previous set until the new frame completes.
- Gaps (din_valid low) are allowed anywhere. State and outputs hold.
- Downstream drives Berlekamp enable low while syn_valid is high to initialise it. Syndromes stay stable for at least 255 cycles, which covers the 16-iteration Berlekamp run.

## Timing
- Reset values: syndrome0..15 = 0x00, syn_valid = 0, err_flag = 0, busy = 0; internally acc = 0, cnt = 0. Reset mid-frame abandons the frame; no syn_valid follows.
- Latency: syndromes, err_flag and syn_valid are all visible in the cycle after the edge that accepts symbol 255.
- Throughput: one symbol per cycle, back-to-back frames with zero bubbles.
- syn_valid never rises twice within 255 cycles.
- All outputs are registered. The combinational path is at most one constant multiply plus XOR before the register.

## Test plan
- Reset, then 255 symbols of 0x00 (sop on the first) -> one syn_valid pulse; all syndromes 0x00; err_flag = 0.
- 254 × 0x00 then final symbol 0x01 (degree 0) -> all syndromes = 0x01; err_flag = 1.
- First symbol 0x01 (degree 254), rest 0x00 -> syndrome_i = α^(-(i+1)): syndrome0 = 0x8E, syndrome1 = 0x47; err_flag = 1.
- Same stimulus as the previous case, with din_valid randomly deasserted about 30% of cycles -> identical syndromes; syn_valid exactly once, one cycle after the 255th accepted symbol.
- din_sop reasserted after 100 symbols, then a full all-zero frame -> no pulse for the aborted frame; one pulse with all zeros and err_flag = 0.
- clrn pulsed low at symbol 200, then a fresh frame with the degree-0 error -> no pulse before the fresh frame; result all 0x01. Two back-to-back frames with no gap -> two pulses 255 cycles apart, each with correct values.
